// File: rtl/zynet_inference_ctrl_if.sv
// Handshake and data bundle between the zyNet inference controller
// and its environment (input serializer, zyNet core, result sink).
interface zynet_inference_ctrl_if #(
    parameter int OUTPUT_SIZE = 10,
    parameter int WORD_SIZE   = 16,
    parameter int CNT_WIDTH   = 16
);
    localparam int CLS_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    logic                                  frame_valid_i;
    logic                                  frame_ready_o;
    logic                                  net_start_o;
    logic                                  net_valid_i;
    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] net_data_i;
    logic                                  net_yumi_o;
    logic                                  valid_o;
    logic                                  yumi_i;
    logic [CLS_W-1:0]                      class_o;
    logic [WORD_SIZE-1:0]                  score_o;
    logic                                  busy_o;
    logic                                  timeout_o;
    logic [CNT_WIDTH-1:0]                  frame_count_o;

    modport master (
        input  frame_valid_i,
        output frame_ready_o,
        output net_start_o,
        input  net_valid_i,
        input  net_data_i,
        output net_yumi_o,
        output valid_o,
        input  yumi_i,
        output class_o,
        output score_o,
        output busy_o,
        output timeout_o,
        output frame_count_o
    );

    modport slave (
        output frame_valid_i,
        input  frame_ready_o,
        input  net_start_o,
        output net_valid_i,
        output net_data_i,
        input  net_yumi_o,
        input  valid_o,
        output yumi_i,
        input  class_o,
        input  score_o,
        input  busy_o,
        input  timeout_o,
        input  frame_count_o
    );
endinterface

// File: rtl/zynet_inference_ctrl.sv
// One-inference-at-a-time sequencer for zyNet: start, wait with
// watchdog, serial signed argmax, result on a valid/yumi handshake.
module zynet_inference_ctrl #(
    parameter int OUTPUT_SIZE    = 10,
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    zynet_inference_ctrl_if.master bus
);
    localparam int IW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(OUTPUT_SIZE - 1);
    localparam logic [TW-1:0] T_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t                                state_q, state_d;
    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] vec_q, vec_d;
    logic signed [WORD_SIZE-1:0]           best_q, best_d;
    logic signed [WORD_SIZE-1:0]           cur_w;
    logic [IW-1:0]                         best_idx_q, best_idx_d;
    logic [IW-1:0]                         idx_q, idx_d;
    logic [TW-1:0]                         timer_q, timer_d;
    logic                                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d;
    logic                                  expire;

    // State and datapath registers; reset drops any in-flight inference.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: sequencing, watchdog and one-word-per-cycle argmax.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        cur_w      = vec_q[idx_q];
        expire     = WDOG_EN && (timer_q == T_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_valid_i) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still wins.
                if (bus.net_valid_i) begin
                    vec_d      = bus.net_data_i;
                    best_d     = bus.net_data_i[0];
                    best_idx_d = '0;
                    idx_d      = IW'(1);
                    state_d    = (OUTPUT_SIZE == 1) ? S_DONE : S_ARGMAX;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_ARGMAX: begin
                // Strict compare keeps the lower index on ties.
                if (cur_w > best_q) begin
                    best_d     = cur_w;
                    best_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.yumi_i) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulses are masked during reset so an aborted START/WAIT emits nothing.
    assign bus.frame_ready_o = (state_q == S_IDLE);
    assign bus.net_start_o   = (state_q == S_START) && !reset_i;
    assign bus.net_yumi_o    = (state_q == S_WAIT) && bus.net_valid_i
                               && !reset_i;
    assign bus.valid_o       = (state_q == S_DONE);
    assign bus.class_o       = best_idx_q;
    assign bus.score_o       = best_q;
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.timeout_o     = timeout_q;
    assign bus.frame_count_o = cnt_q;
endmodule

// File: tb/tb_zynet_inference_ctrl.sv
// Directed bench for zynet_inference_ctrl: default instance plus a
// short-watchdog instance, selected by sel.
module tb_zynet_inference_ctrl;
    localparam int OS  = 10;
    localparam int WS  = 16;
    localparam int CW  = 16;
    localparam int CLW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zynet_inference_ctrl_if #(.OUTPUT_SIZE(OS), .WORD_SIZE(WS),
                              .CNT_WIDTH(CW)) dif ();
    zynet_inference_ctrl_if #(.OUTPUT_SIZE(OS), .WORD_SIZE(WS),
                              .CNT_WIDTH(CW)) wif ();

    zynet_inference_ctrl #(
        .OUTPUT_SIZE(OS), .WORD_SIZE(WS),
        .TIMEOUT_CYCLES(4096), .CNT_WIDTH(CW)
    ) u_dut (
        .clk_i(clk), .reset_i(rst), .bus(dif.master)
    );

    zynet_inference_ctrl #(
        .OUTPUT_SIZE(OS), .WORD_SIZE(WS),
        .TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)
    ) u_wdt (
        .clk_i(clk), .reset_i(rst), .bus(wif.master)
    );

    logic           fv, nv, yu;
    logic [OS*WS-1:0] nd;
    int             sel;

    assign dif.frame_valid_i = fv && (sel == 0);
    assign dif.net_valid_i   = nv && (sel == 0);
    assign dif.yumi_i        = yu && (sel == 0);
    assign dif.net_data_i    = nd;
    assign wif.frame_valid_i = fv && (sel == 1);
    assign wif.net_valid_i   = nv && (sel == 1);
    assign wif.yumi_i        = yu && (sel == 1);
    assign wif.net_data_i    = nd;

    logic           o_ready, o_start, o_yumi, o_valid;
    logic           o_busy, o_timeout;
    logic [CLW-1:0] o_class;
    logic [WS-1:0]  o_score;
    logic [CW-1:0]  o_count;

    always_comb begin
        if (sel == 1) begin
            o_ready   = wif.frame_ready_o;
            o_start   = wif.net_start_o;
            o_yumi    = wif.net_yumi_o;
            o_valid   = wif.valid_o;
            o_busy    = wif.busy_o;
            o_timeout = wif.timeout_o;
            o_class   = wif.class_o;
            o_score   = wif.score_o;
            o_count   = wif.frame_count_o;
        end else begin
            o_ready   = dif.frame_ready_o;
            o_start   = dif.net_start_o;
            o_yumi    = dif.net_yumi_o;
            o_valid   = dif.valid_o;
            o_busy    = dif.busy_o;
            o_timeout = dif.timeout_o;
            o_class   = dif.class_o;
            o_score   = dif.score_o;
            o_count   = dif.frame_count_o;
        end
    end

    int starts_n = 0;
    int yumis_n  = 0;
    always @(posedge clk) begin
        if (o_start) starts_n <= starts_n + 1;
        if (o_yumi)  yumis_n  <= yumis_n + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [WS-1:0] wv [OS];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [OS*WS-1:0] pack();
        logic [OS*WS-1:0] r;
        r = '0;
        for (int k = 0; k < OS; k++) r[k*WS +: WS] = wv[k];
        return r;
    endfunction

    // Accept a frame, wait wait_n WAIT cycles, present wv, measure latency
    task automatic do_frame(input int wait_n, input bit hold,
                            output int lat);
        fv = 1'b1;
        cyc(1);
        chk("start_pulse", 32'(o_start), 32'd1);
        if (!hold) fv = 1'b0;
        cyc(1);
        cyc(wait_n);
        nv = 1'b1;
        nd = pack();
        #1;
        chk("net_yumi", 32'(o_yumi), 32'd1);
        cyc(1);
        nv = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            cyc(1);
            lat++;
        end
        fv = 1'b0;
    endtask

    task automatic consume();
        yu = 1'b1;
        cyc(1);
        yu = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, s0, y0, bad;
        rst = 1'b1; fv = 1'b0; nv = 1'b0; yu = 1'b0; nd = '0; sel = 0;
        cyc(3);
        rst = 1'b0;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_class", 32'(o_class), 32'd0);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_tmo", 32'(o_timeout), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_start", 32'(o_start), 32'd0);

        // Ascending ramp, frame_valid held throughout
        for (int k = 0; k < OS; k++) wv[k] = 16'(16'h0100 * k);
        s0 = starts_n; y0 = yumis_n;
        do_frame(20, 1'b1, lat);
        chk("t1_lat", 32'(lat), 32'd10);
        chk("t1_class", 32'(o_class), 32'd9);
        chk("t1_score", 32'(o_score), 32'h0900);
        chk("t1_nstart", 32'(starts_n - s0), 32'd1);
        chk("t1_nyumi", 32'(yumis_n - y0), 32'd1);
        consume();
        chk("t1_count", 32'(o_count), 32'd1);
        chk("t1_ready", 32'(o_ready), 32'd1);
        chk("t1_valid", 32'(o_valid), 32'd0);

        // Stray yumi while idle
        yu = 1'b1;
        cyc(2);
        yu = 1'b0;
        chk("idle_yumi_cnt", 32'(o_count), 32'd1);
        chk("idle_yumi_busy", 32'(o_busy), 32'd0);

        // All negative: signed compare
        for (int k = 0; k < OS; k++) wv[k] = 16'h8000;
        wv[3] = 16'hFFF0;
        do_frame(2, 1'b0, lat);
        chk("neg_lat", 32'(lat), 32'd10);
        chk("neg_class", 32'(o_class), 32'd3);
        chk("neg_score", 32'(o_score), 32'hFFF0);
        consume();

        // Tie keeps lower index, then hold in DONE
        for (int k = 0; k < OS; k++) wv[k] = 16'h0000;
        wv[2] = 16'h1000;
        wv[7] = 16'h1000;
        do_frame(0, 1'b0, lat);
        chk("tie_class", 32'(o_class), 32'd2);
        chk("tie_score", 32'(o_score), 32'h1000);
        s0 = starts_n;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            fv = 1'($urandom_range(0, 1));
            nd = {5{$urandom}};
            cyc(1);
            if (o_class !== 4'd2 || o_score !== 16'h1000 ||
                o_ready !== 1'b0 || o_valid !== 1'b1) bad++;
        end
        fv = 1'b0;
        chk("hold_stable", 32'(bad), 32'd0);
        chk("hold_nstart", 32'(starts_n - s0), 32'd0);
        consume();
        chk("hold_count", 32'(o_count), 32'd3);

        // Reset during ARGMAX at idx 4
        for (int k = 0; k < OS; k++) wv[k] = 16'(16'h0010 * k);
        wv[5] = 16'h7FFF;
        fv = 1'b1;
        cyc(1);
        fv = 1'b0;
        cyc(3);
        nv = 1'b1;
        nd = pack();
        cyc(1);
        nv = 1'b0;
        cyc(3);
        chk("ar_busy_pre", 32'(o_busy), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("ar_busy", 32'(o_busy), 32'd0);
        chk("ar_valid", 32'(o_valid), 32'd0);
        chk("ar_ready", 32'(o_ready), 32'd1);
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_class", 32'(o_class), 32'd0);
        chk("ar_score", 32'(o_score), 32'd0);
        for (int k = 0; k < OS; k++) wv[k] = 16'(16'hFFFF - k);
        do_frame(1, 1'b0, lat);
        chk("post_lat", 32'(lat), 32'd10);
        chk("post_class", 32'(o_class), 32'd0);
        chk("post_score", 32'(o_score), 32'hFFFF);
        consume();
        chk("post_count", 32'(o_count), 32'd1);

        // Watchdog instance: result on the expiry cycle wins
        sel = 1;
        #1;
        for (int k = 0; k < OS; k++) wv[k] = 16'(16'h0100 * k);
        do_frame(7, 1'b0, lat);
        chk("exp_lat", 32'(lat), 32'd10);
        chk("exp_class", 32'(o_class), 32'd9);
        chk("exp_tmo", 32'(o_timeout), 32'd0);
        consume();
        chk("exp_count", 32'(o_count), 32'd1);

        // Watchdog expiry with no result
        fv = 1'b1;
        cyc(1);
        fv = 1'b0;
        cyc(1);
        cyc(7);
        chk("wd_pre_tmo", 32'(o_timeout), 32'd0);
        chk("wd_pre_busy", 32'(o_busy), 32'd1);
        cyc(1);
        chk("wd_tmo", 32'(o_timeout), 32'd1);
        chk("wd_busy", 32'(o_busy), 32'd0);
        chk("wd_ready", 32'(o_ready), 32'd1);
        chk("wd_valid", 32'(o_valid), 32'd0);
        chk("wd_count", 32'(o_count), 32'd1);

        // Next frame still completes; flag stays sticky
        for (int k = 0; k < OS; k++) wv[k] = 16'h0000;
        wv[2] = 16'h1000;
        wv[7] = 16'h1000;
        do_frame(3, 1'b0, lat);
        chk("wd2_class", 32'(o_class), 32'd2);
        chk("wd2_tmo", 32'(o_timeout), 32'd1);
        consume();
        chk("wd2_count", 32'(o_count), 32'd2);
        chk("wd2_tmo_idle", 32'(o_timeout), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/zynet_inference_ctrl.md
Name: zynet_inference_ctrl

Overview:
Sequences one inference at a time through the zyNet core. It accepts a "frame loaded" handshake from the input-serializer side and pulses the network start. It then waits for the network output vector, acknowledges it, and computes a serial signed argmax over the output words. The winning class index and its score are presented downstream on a valid/yumi handshake. A configurable watchdog aborts inferences that never complete and flags a sticky error.

Parameters:
OUTPUT_SIZE, 10, number of network output words (classes); must be >= 1
WORD_SIZE, 16, bits per output word, two's-complement fixed point
TIMEOUT_CYCLES, 4096, max cycles spent in WAIT before abort; 0 disables the watchdog
CNT_WIDTH, 16, width of the completed-frame counter

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_i  in  1  synchronous, active-high reset
frame_valid_i  in  1  upstream has a full input frame queued for the network
frame_ready_o  out  1  controller can accept a new frame (IDLE only)
net_start_o  out  1  one-cycle start pulse to zyNet start_i
net_valid_i  in  1  zyNet valid_o
net_data_i  in  OUTPUT_SIZE*WORD_SIZE  zyNet data_o, packed [OUTPUT_SIZE-1:0][WORD_SIZE-1:0], signed words
net_yumi_o  out  1  zyNet yumi_i
valid_o  out  1  class result available
yumi_i  in  1  downstream consumes result
class_o  out  max(1,$clog2(OUTPUT_SIZE))  argmax index
score_o  out  WORD_SIZE  signed value at argmax index
busy_o  out  1  state != IDLE
timeout_o  out  1  sticky watchdog error flag
frame_count_o  out  CNT_WIDTH  completed (consumed) inferences, wraps modulo 2^CNT_WIDTH

Behaviour:
- Clock is clk_i. Reset is reset_i, synchronous and active-high.
- Reset: state=IDLE; net_start_o=0, net_yumi_o=0, valid_o=0, class_o=0, score_o=0, timeout_o=0, frame_count_o=0; busy_o=0; frame_ready_o=1 from the first cycle after reset.
- Reset asserted in any state aborts the operation. No start or yumi pulse is issued in that cycle. The captured vector is discarded.
- States:
  - IDLE, START, WAIT, ARGMAX, DONE.
- IDLE:
  - frame_ready_o=1.
  - frame_valid_i && frame_ready_o -> START.
- START:
  - net_start_o=1 for exactly this one cycle.
  - Watchdog timer cleared.
  - Next state is WAIT unconditionally.
- WAIT:
  - net_yumi_o = net_valid_i, combinational and asserted only in WAIT.
  - On net_valid_i: capture net_data_i into an internal vector register; best=word[0], best_idx=0, idx=1.
  - Next state after capture is ARGMAX, or DONE if OUTPUT_SIZE==1.
  - Otherwise timer increments.
  - If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with no net_valid_i that cycle: timeout_o<=1 (sticky until reset), go to IDLE, no output produced, frame_count_o unchanged.
  - net_valid_i on the same cycle as expiry wins: the capture proceeds and no timeout is flagged.
- ARGMAX:
  - One word per cycle from the captured vector; net_data_i is not re-read.
  - Signed compare: if word[idx] > best (strictly greater), then best<=word[idx], best_idx<=idx. Ties keep the lower index.
  - idx==OUTPUT_SIZE-1 processed -> DONE. ARGMAX lasts exactly OUTPUT_SIZE-1 cycles.
- DONE:
  - valid_o=1; class_o=best_idx and score_o=best, held stable while valid_o=1.
  - valid_o && yumi_i -> IDLE, frame_count_o increments. A new frame can be accepted the following cycle.
  - yumi_i while valid_o=0 is ignored.
- Latency: if frame_valid_i is accepted at cycle t, net_start_o=1 at t+1. If net_valid_i first arrives at cycle w, valid_o=1 at w+OUTPUT_SIZE (w+1 when OUTPUT_SIZE==1).
- frame_valid_i is ignored outside IDLE; upstream holds it until frame_ready_o.
- Word extraction: word[k] = net_data_i[k*WORD_SIZE +: WORD_SIZE], treated as signed.

Test Plan:
- Reset, frame_valid_i=1 held, then net_valid_i after 20 cycles with words {k: 16'h0100*k}, k=0..9 -> one net_start_o pulse; net_yumi_o for 1 cycle; valid_o 10 cycles after net_valid_i with class_o=9, score_o=16'h0900; yumi_i -> frame_count_o=1.
- All-negative vector with word[3]=16'hFFF0 (-16) and the rest 16'h8000 -> class_o=3, score_o=16'hFFF0; confirms signed compare.
- Tie: word[2]=word[7]=16'h1000, rest 0 -> class_o=2.
- TIMEOUT_CYCLES=8, never assert net_valid_i -> timeout_o=1 on the 8th WAIT cycle, return to IDLE, valid_o stays 0, frame_count_o unchanged; the next frame still completes normally and timeout_o remains 1.
- Hold yumi_i=0 for 50 cycles in DONE while toggling frame_valid_i and net_data_i -> class_o/score_o stable, frame_ready_o=0, no extra net_start_o.
- Assert reset_i during ARGMAX (idx=4) -> next cycle state IDLE, valid_o=0, frame_ready_o=1, counters zero; a subsequent frame gives the correct result.
